// File: rtl/mem_readback_streamer.sv
// -----------------------------------------------------------------------------
// mem_readback_streamer
//
// Streams a block of 32-bit words out of a synchronous-read memory into a
// pipe-out FIFO.
//
// A start pulse latches the byte address and byte count. The byte count is
// rounded up to whole words and clamped to the size of the memory. Reads then
// issue at up to one word per cycle, and the address wraps at the end of the
// memory. Returned data passes through a 2-entry in-order skid buffer, so a
// read already in flight still has a slot when fifo_full rises. When the skid
// buffer is empty, the word arriving from the memory goes straight to the
// FIFO. The first FIFO write therefore comes two cycles after start.
//
// Optional feature (macro MEM_READBACK_CHECKSUM_EN):
//   adds output checksum, the mod-2^32 sum of the words written to the FIFO
//   in the current or last transfer.
//
// Ports
//   core_clk    in   sole clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   one-cycle request to begin a readback (IDLE only)
//   abort       in   level, terminates an active transfer
//   base_addr   in   byte start address, bits [1:0] ignored
//   byte_count  in   bytes to read, sampled with start
//   mem_en      out  memory read enable
//   mem_addr    out  word-aligned byte address of the read
//   mem_dout    in   read data, valid one cycle after mem_en
//   fifo_din    out  word to the FIFO (oldest buffered word)
//   fifo_wr_en  out  FIFO write strobe
//   fifo_full   in   FIFO cannot accept a write this cycle
//   busy        out  high in any state except IDLE
//   done        out  one-cycle pulse after completion or abort
//   words_sent  out  words written to the FIFO in the current or last transfer
//   checksum    out  (MEM_READBACK_CHECKSUM_EN only) sum of the words written
// -----------------------------------------------------------------------------
module mem_readback_streamer #(
    parameter int unsigned MEM_BYTES = 32'h8000,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              core_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       byte_count,
    output logic              mem_en,
    output logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              busy,
    output logic              done,
    output logic [31:0]       words_sent
`ifdef MEM_READBACK_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [31:0] MAX_BYTES = 32'(MEM_BYTES);
    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [31:0]       req_words;
    logic [31:0]       rd_ptr;
    logic [31:0]       remaining;
    logic [31:0]       total_words;
    logic [31:0]       sent_q;
    logic              rd_valid;      // a read issued last cycle returns now
    logic [1:0]        skid_cnt;
    logic [DATA_W-1:0] skid_q [2];    // [0] is the oldest entry
    logic [2:0]        in_use;

    logic              accept;
    logic              xfer_active;
    logic              kill;
    logic              issue;
    logic              head_valid;
    logic              wr;

    // Word count for a new request: ceil(byte_count/4), clamped to the memory.
    // NOTE: every variable in an always_comb gets a default first, so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        req_words = '0;
        if (byte_count > MAX_BYTES) begin
            req_words = MAX_WORDS;
        end else begin
            req_words = (byte_count >> 2) + {31'd0, |byte_count[1:0]};
        end
    end

    // Start is ignored when it coincides with abort.
    assign accept      = (state == IDLE) && start && !abort;
    assign xfer_active = (state == READ) || (state == DRAIN);
    assign kill        = xfer_active && abort;

    // Buffered words plus the read in flight must never exceed the two skid
    // slots, so a new read issues only while their sum is below 2.
    assign in_use      = {1'b0, skid_cnt} + {2'b00, rd_valid};
    assign issue       = (state == READ) && !abort && (remaining != '0) && (in_use < 3'd2);

    // Returning data counts as present in the skid buffer in the cycle it
    // arrives. Writing it straight through keeps the rate at one word per cycle.
    assign head_valid  = (skid_cnt != 2'd0) || rd_valid;
    assign wr          = xfer_active && !abort && head_valid && !fifo_full;

    assign mem_addr    = rd_ptr;
    assign words_sent  = sent_q;

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (req_words == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (abort) begin
                    next_state = FINISH;
                end else if (issue && (remaining == 32'd1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    next_state = FINISH;
                end else if (sent_q == total_words) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state != IDLE);
        mem_en     = issue;
        fifo_wr_en = wr;
        fifo_din   = '0;
        if (skid_cnt != 2'd0) begin
            fifo_din = skid_q[0];
        end else if (rd_valid) begin
            fifo_din = mem_dout;
        end
    end

    // Transfer bookkeeping: pointer, counters, skid occupancy, done pulse.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            remaining   <= '0;
            total_words <= '0;
            sent_q      <= '0;
            rd_valid    <= 1'b0;
            skid_cnt    <= 2'd0;
            done        <= 1'b0;
        end else begin
            // done follows the single FINISH cycle, one cycle late.
            done <= (state == FINISH);
            if (accept) begin
                rd_ptr      <= base_addr & ADDR_MASK & 32'hFFFF_FFFC;
                remaining   <= req_words;
                total_words <= req_words;
                sent_q      <= '0;
                rd_valid    <= 1'b0;
                skid_cnt    <= 2'd0;
            end else begin
                if (issue) begin
                    rd_ptr    <= (rd_ptr + 32'd4) & ADDR_MASK;
                    remaining <= remaining - 32'd1;
                end
                if (wr) begin
                    sent_q <= sent_q + 32'd1;
                end
                if (kill) begin
                    // Drop buffered words and the read still in flight.
                    rd_valid  <= 1'b0;
                    skid_cnt  <= 2'd0;
                    remaining <= '0;
                end else begin
                    rd_valid <= issue;
                    case ({wr, rd_valid})
                        2'b01:   skid_cnt <= skid_cnt + 2'd1;
                        2'b10:   skid_cnt <= skid_cnt - 2'd1;
                        default: skid_cnt <= skid_cnt;
                    endcase
                end
            end
        end
    end

    // Skid buffer storage. A word that arrives while the buffer is empty and
    // is written through at once is never stored.
    // NOTE: the data slots have no reset. skid_cnt alone marks them valid,
    // and fifo_din is forced to zero while the buffer is empty.
    always_ff @(posedge core_clk) begin
        if (rd_valid) begin
            if (wr) begin
                if (skid_cnt == 2'd1) begin
                    skid_q[0] <= mem_dout;
                end
            end else if (skid_cnt == 2'd0) begin
                skid_q[0] <= mem_dout;
            end else begin
                skid_q[1] <= mem_dout;
            end
        end else if (wr) begin
            skid_q[0] <= skid_q[1];
        end
    end

`ifdef MEM_READBACK_CHECKSUM_EN
    // Running sum of the words written. It stops changing on abort because
    // writes are suppressed from the abort cycle onwards.
    logic [31:0] checksum_q;

    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= '0;
        end else if (wr) begin
            checksum_q <= checksum_q + 32'(fifo_din);
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: doc/mem_readback_streamer.md
MEM_READBACK_STREAMER -- requirements
Module: mem_readback_streamer

Interface
REQ-001 Parameter MEM_BYTES, default 32'h8000, memory size in bytes; power of two, multiple of 4.
REQ-002 Parameter DATA_W, default 32, word width; fixed at 32.
REQ-003 core_clk  in  1  sole clock; all logic rises on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to begin a readback; honoured only in IDLE.
REQ-006 abort  in  1  level; terminates an active transfer.
REQ-007 base_addr  in  32  byte start address; bits [1:0] ignored.
REQ-008 byte_count  in  32  bytes to read; sampled with start.
REQ-009 mem_en  out  1  memory read enable.
REQ-010 mem_addr  out  32  word-aligned byte address.
REQ-011 mem_dout  in  32  read data, valid exactly 1 cycle after mem_en.
REQ-012 fifo_din  out  32  word to the pipe-out FIFO.
REQ-013 fifo_wr_en  out  1  FIFO write strobe.
REQ-014 fifo_full  in  1  FIFO cannot accept a write this cycle.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done  out  1  one-cycle pulse on transfer completion or abort.
REQ-017 words_sent  out  32  words written to the FIFO in the current or last transfer.

Function
REQ-018 The state machine shall have states IDLE, READ, DRAIN, FINISH.
REQ-019 IDLE->READ on start with word count N=ceil(byte_count/4)>0; IDLE->FINISH on start with N=0.
REQ-020 On start, words_sent shall clear, the read pointer shall load {base_addr[31:2],2'b00} mod MEM_BYTES, and the remaining-issue counter shall load N.
REQ-021 In READ, mem_en shall assert only when the remaining-issue count is nonzero and occupied skid slots plus reads in flight are fewer than 2.
REQ-022 Each issued read shall advance mem_addr by 4, wrapping MEM_BYTES-4 -> 0.
REQ-023 Returned mem_dout shall enter a 2-entry in-order skid buffer one cycle after issue.
REQ-024 fifo_wr_en shall assert when the skid buffer is non-empty and fifo_full is low; fifo_din shall be the oldest entry; words_sent shall increment on each such write.
REQ-025 No word shall be lost or duplicated under any fifo_full pattern; fifo_wr_en shall never assert while fifo_full is high.
REQ-026 READ->DRAIN when the last read issues; DRAIN->FINISH when words_sent reaches N.
REQ-027 FINISH shall pulse done for one cycle, then return to IDLE.
REQ-028 Steady-state throughput shall be 1 word/cycle with fifo_full low; first fifo_wr_en shall assert 2 cycles after start.
REQ-029 abort in READ or DRAIN shall stop issuing, discard the skid buffer and in-flight data, go to FINISH, and freeze words_sent.
REQ-030 start while busy shall be ignored; abort and start in the same cycle in IDLE shall ignore start.
REQ-031 byte_count values above MEM_BYTES shall be clamped to MEM_BYTES/4 words.

Reset
REQ-032 reset shall force IDLE, mem_en=0, fifo_wr_en=0, done=0, busy=0, words_sent=0, mem_addr=0, fifo_din=0, and empty the skid buffer.
REQ-033 reset asserted mid-transfer shall take effect immediately, with no done pulse.

Configuration
REQ-034 When macro MEM_READBACK_CHECKSUM_EN is defined, output checksum[31:0] shall be added; it clears on start and holds the mod-2^32 sum of all words written to the FIFO. It resets to 0 and is not updated after abort.
REQ-035 When MEM_READBACK_CHECKSUM_EN is undefined, the checksum port and its logic shall be absent, with all other behaviour identical.

Verification
REQ-036 Memory word i = 0xA5000000+i, base=0, byte_count=16, fifo_full=0 -> 4 writes 0xA5000000..0xA5000003 on consecutive cycles, done pulse, words_sent=4.
REQ-037 Same, byte_count=10 -> 3 words written (ceil rounding); byte_count=0 -> no mem_en, done 2 cycles after start.
REQ-038 base=MEM_BYTES-8, byte_count=16 -> addresses 0x7FF8, 0x7FFC, 0x0000, 0x0004 in order.
REQ-039 byte_count=64 with fifo_full toggling randomly at 50% -> all 16 words delivered exactly once and in order; no fifo_wr_en while full.
REQ-040 abort asserted after 5 words, fifo_full held high -> mem_en drops next cycle, done pulses, words_sent=5, busy low after FINISH.
REQ-041 With MEM_READBACK_CHECKSUM_EN defined, 4 words of 0x00000001 -> checksum=4; reset mid-transfer -> checksum=0, busy=0, no done pulse.
